// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI bus arbiter.
package pci_pkg;

  typedef enum logic [1:0] {
    TURN  = 2'd0,
    PARK  = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } arb_state_t;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  function automatic int ow_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Round-robin priority search: first asserted (low) Req starting at the pointer.
module pci_rr_pick
  import pci_pkg::*;
#(
  parameter  int N_MASTERS = 4,
  localparam int OW        = ow_of(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req_n,
  input  logic [OW-1:0]        i_ptr,
  output logic [OW-1:0]        o_winner,
  output logic                 o_any_req
);

  logic        w_found;
  int unsigned w_idx;

  always_comb begin
    w_found  = 1'b0;
    w_idx    = 0;
    o_winner = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= N_MASTERS) w_idx = w_idx - N_MASTERS;
      if (!w_found && i_req_n[w_idx] == ASSERTED) begin
        w_found  = 1'b1;
        o_winner = OW'(w_idx);
      end
    end
    o_any_req = w_found;
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central round-robin arbiter for the shared PCI bus: turnaround, parking,
// and revocation of unused grants.
module pci_bus_arbiter
  import pci_pkg::*;
#(
  parameter  int N_MASTERS   = 4,
  parameter  int PARK_MASTER = 0,
  parameter  int GNT_TIMEOUT = 16,
  localparam int OW          = ow_of(N_MASTERS)
) (
  input  logic                 Clock,
  input  logic                 RST,
  input  logic [N_MASTERS-1:0] Req,
  input  logic                 Frame,
  input  logic                 Irdy,
  output logic [N_MASTERS-1:0] Gnt,
  output logic [OW-1:0]        Owner,
  output logic                 BusIdle,
  output logic                 GntTimeout
);

  localparam int              CW        = $clog2(GNT_TIMEOUT) + 1;
  localparam logic [OW-1:0]   PARK_IDX  = OW'(PARK_MASTER);
  localparam logic [OW-1:0]   LAST_IDX  = OW'(N_MASTERS - 1);
  localparam logic [CW-1:0]   CNT_LIMIT = CW'(GNT_TIMEOUT - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [OW-1:0]        r_owner, w_owner_nxt;
  logic [OW-1:0]        r_rr_ptr, w_rr_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [N_MASTERS-1:0] r_gnt, w_gnt_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_bus_idle;

  logic [OW-1:0]        w_winner;
  logic                 w_any_req;
  logic                 w_other_req;
  logic [OW-1:0]        w_owner_inc;

  pci_rr_pick #(
    .N_MASTERS(N_MASTERS)
  ) u_pick (
    .i_req_n  (Req),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any_req(w_any_req)
  );

  always_comb begin
    w_other_req = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (k != PARK_MASTER && Req[k] == ASSERTED) w_other_req = 1'b1;
    end
  end

  assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_nxt      = r_rr_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      TURN: begin
        if (w_any_req) begin
          w_owner_nxt = w_winner;
          w_state_nxt = GRANT;
          w_cnt_nxt   = '0;
        end else begin
          w_owner_nxt = PARK_IDX;
          w_state_nxt = PARK;
        end
      end
      PARK: begin
        if (Frame == ASSERTED)  w_state_nxt = BUSY;
        else if (w_other_req)   w_state_nxt = TURN;
      end
      GRANT: begin
        w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        // Frame wins over withdrawal and timeout in the same cycle.
        if (Frame == ASSERTED) begin
          w_state_nxt = BUSY;
          w_rr_nxt    = w_owner_inc;
        end else if (Req[r_owner] == DEASSERTED) begin
          w_state_nxt = TURN;
        end else if (r_cnt == CNT_LIMIT) begin
          w_state_nxt   = TURN;
          w_rr_nxt      = w_owner_inc;
          w_timeout_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (Frame == DEASSERTED && Irdy == DEASSERTED) w_state_nxt = TURN;
      end
      default: w_state_nxt = TURN;
    endcase
  end

  // Gnt is registered from the next state so it lines up with the state it reflects.
  always_comb begin
    w_gnt_nxt = '1;
    case (w_state_nxt)
      PARK:        w_gnt_nxt[PARK_IDX]    = ASSERTED;
      GRANT, BUSY: w_gnt_nxt[w_owner_nxt] = ASSERTED;
      default:     w_gnt_nxt = '1;
    endcase
  end

  always_ff @(posedge Clock or posedge RST) begin
    if (RST) begin
      r_state    <= TURN;
      r_owner    <= PARK_IDX;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_gnt      <= '1;
      r_timeout  <= 1'b0;
      r_bus_idle <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_bus_idle <= Frame & Irdy;
    end
  end

  assign Gnt        = r_gnt;
  assign Owner      = r_owner;
  assign BusIdle    = r_bus_idle;
  assign GntTimeout = r_timeout;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_pci_bus_arbiter;

  localparam int N    = 4;
  localparam int PARK = 0;
  localparam int TO   = 16;

  logic       Clock = 1'b0;
  logic       RST;
  logic [3:0] Req;
  logic       Frame;
  logic       Irdy;
  logic [3:0] Gnt;
  logic [1:0] Owner;
  logic       BusIdle;
  logic       GntTimeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: who holds the grant (-1 = nobody) and what they are doing.
  int m_gnt;
  bit m_in_use;
  bit m_parked;
  int m_wait;
  int m_ptr;
  int m_owner;
  bit m_idle;
  bit m_to;

  pci_bus_arbiter #(
    .N_MASTERS  (N),
    .PARK_MASTER(PARK),
    .GNT_TIMEOUT(TO)
  ) dut (
    .Clock     (Clock),
    .RST       (RST),
    .Req       (Req),
    .Frame     (Frame),
    .Irdy      (Irdy),
    .Gnt       (Gnt),
    .Owner     (Owner),
    .BusIdle   (BusIdle),
    .GntTimeout(GntTimeout)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] gnt_vec(input int idx);
    logic [3:0] v;
    v = 4'b1111;
    if (idx >= 0) v[idx] = 1'b0;
    return v;
  endfunction

  function automatic int low_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (g[i] === 1'b0) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = -1; m_in_use = 0; m_parked = 0; m_wait = 0;
    m_ptr = 0; m_owner = PARK; m_idle = 1; m_to = 0;
  endtask

  task automatic model_step();
    int w;
    if (RST) begin
      model_reset();
      return;
    end
    m_to   = 0;
    m_idle = Frame & Irdy;
    if (m_gnt < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && Req[(m_ptr + k) % N] == 1'b0) w = (m_ptr + k) % N;
      end
      m_in_use = 0;
      m_wait   = 0;
      if (w >= 0) begin
        m_gnt = w; m_owner = w; m_parked = 0;
      end else begin
        m_gnt = PARK; m_owner = PARK; m_parked = 1;
      end
    end else if (m_in_use) begin
      if (Frame && Irdy) m_gnt = -1;
    end else if (m_parked) begin
      if (!Frame) m_in_use = 1;
      else if ((~Req & ~(4'b0001 << PARK)) != 4'b0000) m_gnt = -1;
    end else begin
      m_wait++;
      if (!Frame) begin
        m_in_use = 1;
        m_ptr = (m_owner + 1) % N;
      end else if (Req[m_owner]) begin
        m_gnt = -1;
      end else if (m_wait == TO) begin
        m_gnt = -1;
        m_ptr = (m_owner + 1) % N;
        m_to  = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},     32'(Gnt),        32'(gnt_vec(m_gnt)));
    chk({tag, ".owner"},   32'(Owner),      32'(m_owner));
    chk({tag, ".busidle"}, 32'(BusIdle),    32'(m_idle));
    chk({tag, ".timeout"}, 32'(GntTimeout), 32'(m_to));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge Clock);
    #1;
    check_all(tag);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    RST = 1'b1; Req = 4'b1111; Frame = 1'b1; Irdy = 1'b1;
    model_reset();
    @(posedge Clock); #1;
    check_all("t1.rst");
    chk("t1.rst_gnt", 32'(Gnt), 32'h0000000f);

    // 1: release, one turnaround, then park on master 0
    RST = 1'b0;
    cyc("t1");
    chk("t1.park_gnt", 32'(Gnt), 32'h0000000e);
    chk("t1.park_owner", 32'(Owner), 32'd0);

    // 2: master 2 request from parked
    Req = 4'b1011;
    cyc("t2.turn");
    chk("t2.turn_gnt", 32'(Gnt), 32'h0000000f);
    cyc("t2.grant");
    chk("t2.grant_gnt", 32'(Gnt), 32'h0000000b);
    cyc("t2.hold1");
    cyc("t2.hold2");
    Frame = 1'b0;
    cyc("t2.busy");
    Frame = 1'b1; Irdy = 1'b0; Req = 4'b1111;
    cyc("t2.last");
    Irdy = 1'b1;
    cyc("t2.idle");
    cyc("t2.repark");
    chk("t2.repark_gnt", 32'(Gnt), 32'h0000000e);

    // 3: everyone requesting from a fresh pointer
    RST = 1'b1; Req = 4'b0000;
    cyc("t3.rst");
    RST = 1'b0;
    for (int g = 0; g < 5; g++) begin
      cyc("t3.grant");
      chk("t3.order", 32'(low_idx(Gnt)), 32'(order[g]));
      Frame = 1'b0;
      cyc("t3.busy");
      Frame = 1'b1; Irdy = 1'b0;
      cyc("t3.last");
      Irdy = 1'b1;
      cyc("t3.turn");
      chk("t3.gap", 32'(Gnt), 32'h0000000f);
    end

    // 4: master 1 never asserts Frame
    Req = 4'b1101;
    cyc("t4.grant");
    chk("t4.grant_gnt", 32'(Gnt), 32'h0000000d);
    for (int i = 1; i < TO; i++) begin
      cyc("t4.wait");
      chk("t4.wait_to", 32'(GntTimeout), 32'd0);
    end
    cyc("t4.expire");
    chk("t4.expire_to", 32'(GntTimeout), 32'd1);
    chk("t4.expire_gnt", 32'(Gnt), 32'h0000000f);
    Req = 4'b1001;
    cyc("t4.next");
    chk("t4.next_gnt", 32'(Gnt), 32'h0000000b);
    chk("t4.pulse_end", 32'(GntTimeout), 32'd0);
    Req = 4'b1111;
    cyc("t4.withdraw");
    cyc("t4.park");

    // 5: master 3 in its last data phase
    Req = 4'b0111;
    cyc("t5.turn");
    cyc("t5.grant");
    chk("t5.grant_gnt", 32'(Gnt), 32'h00000007);
    Frame = 1'b0;
    cyc("t5.busy");
    Req = 4'b0000; Frame = 1'b1; Irdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("t5.last");
      chk("t5.hold_gnt", 32'(Gnt), 32'h00000007);
    end
    Irdy = 1'b1;
    cyc("t5.idle");
    chk("t5.idle_gnt", 32'(Gnt), 32'h0000000f);

    // 6: asynchronous reset while master 1 is busy
    Req = 4'b1101;
    cyc("t6.grant");
    Frame = 1'b0;
    cyc("t6.busy");
    chk("t6.busy_gnt", 32'(Gnt), 32'h0000000d);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all("t6.async");
    chk("t6.async_gnt", 32'(Gnt), 32'h0000000f);
    Frame = 1'b1; Irdy = 1'b1; Req = 4'b0000;
    cyc("t6.hold");
    RST = 1'b0;
    cyc("t6.first");
    chk("t6.first_gnt", 32'(Gnt), 32'h0000000e);
    chk("t6.first_owner", 32'(Owner), 32'd0);
    Req = 4'b1111;
    cyc("t6.drop");

    // 7: randomized traffic, alternating free-running and Frame-starved phases
    for (int blk = 0; blk < 40; blk++) begin
      int mode;
      logic [3:0] hold_req;
      mode = $urandom_range(0, 2);
      hold_req = 4'($urandom_range(0, 14));
      for (int i = 0; i < 20; i++) begin
        if (mode == 0) begin
          Req   = 4'($urandom);
          Frame = ($urandom_range(0, 3) != 0);
          Irdy  = ($urandom_range(0, 2) != 0);
        end else if (mode == 1) begin
          Req   = hold_req;
          Frame = 1'b1;
          Irdy  = 1'b1;
        end else begin
          Req   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : hold_req;
          Frame = ($urandom_range(0, 5) != 0);
          Irdy  = ($urandom_range(0, 1) != 0);
        end
        RST = ($urandom_range(0, 199) == 0);
        cyc("t7.rand");
      end
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
